// File: rtl/imem_byte_loader.sv
// imem_byte_loader
//   Writer side of the instruction-memory image path. Packs a little-endian
//   program byte stream (valid/ready) into 32-bit word writes for the
//   instruction memory, so benches and boot logic can load images without
//   a file-based memory preload.
//
// Ports
//   sys_clk    in   clock
//   sys_rst    in   synchronous, active-high reset
//   start      in   1-cycle pulse: begin a load at base_addr (ignored while busy)
//   base_addr  in   start byte address; bits [1:0] are forced to 0
//   s_valid    in   stream byte valid
//   s_data     in   stream byte
//   s_last     in   final byte of the image
//   s_ready    out  loader accepts a byte this cycle
//   mem_we     out  word write request
//   mem_addr   out  word-aligned byte address of the write
//   mem_wdata  out  byte k of the word in bits [8k+7:8k]; unfilled lanes are 0
//   mem_wstrb  out  lane enables
//   mem_ready  in   memory accepts the write this cycle
//   busy       out  load in progress
//   done       out  1-cycle pulse at the end of a load
//   err        out  sticky overflow flag, cleared by the next start
//   csum       out  wrapping byte sum of the load (0 when the option is off)
//
// Build option
//   IMEM_LOADER_CSUM_EN  when defined, csum is the 32-bit wrapping sum of every
//                        accepted byte; otherwise csum is tied to zero.

module imem_byte_loader #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned MEM_BYTES = 16384
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       csum
);

    // One extra address bit so the running address can reach MEM_BYTES
    // without wrapping back into the memory.
    localparam int unsigned AddrExtW = ADDR_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StWrite,
        StDrain,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [AddrExtW-1:0] addr_q, addr_d;
    logic [1:0]          lane_q, lane_d;
    logic [3:0]          strb_q, strb_d;
    logic [31:0]         data_q, data_d;
    logic                last_q, last_d;
    logic                err_q, err_d;

    logic byte_xfer;
    logic word_end;
    logic addr_ovf;

    // The low address bits are discarded by design.
    logic unused_base_lsbs;
    assign unused_base_lsbs = ^base_addr[1:0];

    // Bytes are consumed both while packing and while draining after overflow.
    assign byte_xfer = s_valid && ((state_q == StRecv) || (state_q == StDrain));
    assign word_end  = s_valid && (state_q == StRecv) && ((lane_q == 2'd3) || s_last);
    assign addr_ovf  = (addr_q >= AddrExtW'(MEM_BYTES));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRecv;
                end
            end
            StRecv: begin
                if (word_end) begin
                    // An out-of-range word is never written; keep swallowing
                    // the stream until its last byte.
                    if (addr_ovf) begin
                        state_d = s_last ? StDone : StDrain;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (mem_ready) begin
                    state_d = last_q ? StDone : StRecv;
                end
            end
            StDrain: begin
                if (s_valid && s_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (state only, so mem_ready never reaches an output)
    // ------------------------------------------------------------------
    always_comb begin
        s_ready = 1'b0;
        mem_we  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            StRecv, StDrain: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            StWrite: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign mem_addr  = addr_q[ADDR_W-1:0];
    assign mem_wdata = data_q;
    assign mem_wstrb = strb_q;
    assign err       = err_q;

    // ------------------------------------------------------------------
    // Word packing datapath
    // ------------------------------------------------------------------
    always_comb begin
        addr_d = addr_q;
        lane_d = lane_q;
        strb_d = strb_q;
        data_d = data_q;
        last_d = last_q;
        err_d  = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d = {1'b0, base_addr[ADDR_W-1:2], 2'b00};
                    lane_d = 2'd0;
                    strb_d = 4'b0000;
                    data_d = 32'h0;
                    last_d = 1'b0;
                    err_d  = 1'b0;
                end
            end
            StRecv: begin
                if (s_valid) begin
                    data_d[{lane_q, 3'b000} +: 8] = s_data;
                    strb_d[lane_q]                = 1'b1;
                    lane_d                        = lane_q + 2'd1;
                    last_d                        = s_last;
                    if (word_end && addr_ovf) begin
                        err_d  = 1'b1;
                        lane_d = 2'd0;
                        strb_d = 4'b0000;
                        data_d = 32'h0;
                    end
                end
            end
            StWrite: begin
                if (mem_ready) begin
                    addr_d = addr_q + AddrExtW'(4);
                    lane_d = 2'd0;
                    strb_d = 4'b0000;
                    data_d = 32'h0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            addr_q <= '0;
            lane_q <= 2'd0;
            strb_q <= 4'b0000;
            data_q <= 32'h0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            lane_q <= lane_d;
            strb_q <= strb_d;
            data_q <= data_d;
            last_q <= last_d;
            err_q  <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional checksum
    // ------------------------------------------------------------------
`ifdef IMEM_LOADER_CSUM_EN
    logic [31:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if ((state_q == StIdle) && start) begin
            csum_d = 32'h0;
        end else if (byte_xfer) begin
            csum_d = csum_q + {24'h0, s_data};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            csum_q <= 32'h0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`else
    logic unused_xfer;
    assign unused_xfer = byte_xfer;
    assign csum        = 32'h0;
`endif

endmodule

// File: tb/tb_imem_byte_loader.sv
// Self-checking bench for imem_byte_loader. Expected writes, error flag and
// checksum come from a word-level model of the image layout.

module tb_imem_byte_loader;

    localparam int ADDR_W    = 14;
    localparam int MEM_BYTES = 16384;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_last;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       csum;

    imem_byte_loader #(
        .ADDR_W   (ADDR_W),
        .MEM_BYTES(MEM_BYTES)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .start    (start),
        .base_addr(base_addr),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .csum     (csum)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // Image under test and its expected outcome.
    logic [7:0]        img[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic [3:0]        exp_strb[$];
    logic              exp_err;
    logic [31:0]       exp_csum;

    // Everything the memory side accepted, and every done pulse.
    logic [ADDR_W-1:0] cap_addr[$];
    logic [31:0]       cap_data[$];
    logic [3:0]        cap_strb[$];
    int                done_cnt = 0;

    // Result of the last run_load.
    int          res_w0;
    int          res_nw;
    int          res_taken;
    int          res_dones;
    bit          res_done;
    logic        res_err;
    logic [31:0] res_csum;

    always @(negedge sys_clk) begin
        if (mem_we === 1'b1 && mem_ready === 1'b1) begin
            cap_addr.push_back(mem_addr);
            cap_data.push_back(mem_wdata);
            cap_strb.push_back(mem_wstrb);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic set_img(input logic [63:0] bytes, input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(bytes[8*i +: 8]);
    endtask

    task automatic rand_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(8'($urandom));
    endtask

    // Image layout: byte i lands in lane i%4 of the word at aligned_base+4*(i/4);
    // words at or beyond the memory end are dropped and flag an error.
    task automatic build_model(input logic [ADDR_W-1:0] base);
        int          a, n, nw, wa;
        logic [31:0] d;
        logic [3:0]  s;
        exp_addr.delete();
        exp_data.delete();
        exp_strb.delete();
        exp_err  = 1'b0;
        exp_csum = 32'h0;
        a  = int'(base);
        a  = a - (a % 4);
        n  = img.size();
        nw = (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            wa = a + 4 * w;
            if (wa >= MEM_BYTES) begin
                exp_err = 1'b1;
            end else begin
                d = 32'h0;
                s = 4'h0;
                for (int k = 0; k < 4; k++) begin
                    if (4 * w + k < n) begin
                        d[8*k +: 8] = img[4*w+k];
                        s[k]        = 1'b1;
                    end
                end
                exp_addr.push_back(ADDR_W'(wa));
                exp_data.push_back(d);
                exp_strb.push_back(s);
            end
        end
`ifdef IMEM_LOADER_CSUM_EN
        foreach (img[i]) exp_csum = exp_csum + {24'h0, img[i]};
`endif
    endtask

    // Streams img with random valid/ready gaps until done or a cycle budget.
    task automatic run_load(input logic [ADDR_W-1:0] base, input int vpct, input int rpct,
                            input bit poke_start);
        int idx = 0;
        int cyc = 0;
        int d0;
        res_w0   = cap_addr.size();
        d0       = done_cnt;
        res_done = 1'b0;
        res_err  = 1'b0;
        res_csum = 32'h0;
        @(posedge sys_clk); #1;
        start     = 1'b1;
        base_addr = base;
        s_valid   = 1'b0;
        mem_ready = 1'b0;
        @(posedge sys_clk); #1;
        start = 1'b0;
        while (!res_done && cyc < 2000) begin
            if (idx < img.size() && int'($urandom_range(99)) < vpct) begin
                s_valid = 1'b1;
                s_data  = img[idx];
                s_last  = (idx == img.size() - 1);
            end else begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                s_last  = 1'($urandom);
            end
            mem_ready = (int'($urandom_range(99)) < rpct);
            start     = (poke_start && cyc == 3 && busy === 1'b1);
            base_addr = ADDR_W'($urandom);
            @(negedge sys_clk);
            if (s_valid && s_ready === 1'b1) idx++;
            if (done === 1'b1) begin
                res_done = 1'b1;
                res_err  = err;
                res_csum = csum;
            end
            @(posedge sys_clk); #1;
            cyc++;
        end
        start     = 1'b0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        mem_ready = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        res_taken = idx;
        res_nw    = cap_addr.size() - res_w0;
        res_dones = done_cnt - d0;
    endtask

    task automatic test_reset();
        sys_rst   = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        s_valid   = 1'b0;
        s_data    = 8'h0;
        s_last    = 1'b0;
        mem_ready = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        checks++;
        if ({s_ready, mem_we, busy, done, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000", {s_ready, mem_we, busy, done, err});
        end
        checks++;
        if ({mem_addr, mem_wstrb} !== {14'h0, 4'h0}) begin
            failures++;
            $display("FAIL reset_addr_strb: got %h/%h expected 0/0", mem_addr, mem_wstrb);
        end
        checks++;
        if (mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_wdata: got %h expected 0", mem_wdata);
        end
        checks++;
        if (csum !== 32'h0) begin
            failures++;
            $display("FAIL reset_csum: got %h expected 0", csum);
        end
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
    endtask

    task automatic test_words();
        set_img(64'h0010_0093_0000_0013, 8);
        build_model(14'h0000);
        run_load(14'h0000, 100, 100, 1'b0);
        checks++;
        if (res_nw != 2) begin
            failures++;
            $display("FAIL words_count: got %0d expected 2", res_nw);
        end
        for (int i = 0; i < res_nw && i < exp_addr.size(); i++) begin
            checks++;
            if ({cap_addr[res_w0+i], cap_data[res_w0+i], cap_strb[res_w0+i]} !==
                {exp_addr[i], exp_data[i], exp_strb[i]}) begin
                failures++;
                $display("FAIL words_write%0d: got %h@%h/%h expected %h@%h/%h", i,
                         cap_data[res_w0+i], cap_addr[res_w0+i], cap_strb[res_w0+i],
                         exp_data[i], exp_addr[i], exp_strb[i]);
            end
        end
        if (res_nw >= 2) begin
            checks++;
            if (cap_data[res_w0+1] !== 32'h0010_0093 || cap_addr[res_w0+1] !== 14'h0004) begin
                failures++;
                $display("FAIL words_second: got %h@%h expected 00100093@0004",
                         cap_data[res_w0+1], cap_addr[res_w0+1]);
            end
        end
        checks++;
        if (res_dones != 1 || res_taken != 8) begin
            failures++;
            $display("FAIL words_done: got dones=%0d taken=%0d expected 1/8", res_dones, res_taken);
        end
    endtask

    task automatic test_partial_word();
        set_img(64'h0000_00EE_DDCC_BBAA, 5);
        build_model(14'h0102);
        run_load(14'h0102, 70, 60, 1'b0);
        checks++;
        if (res_nw != exp_addr.size()) begin
            failures++;
            $display("FAIL partial_count: got %0d expected %0d", res_nw, exp_addr.size());
        end
        for (int i = 0; i < res_nw && i < exp_addr.size(); i++) begin
            checks++;
            if ({cap_addr[res_w0+i], cap_data[res_w0+i], cap_strb[res_w0+i]} !==
                {exp_addr[i], exp_data[i], exp_strb[i]}) begin
                failures++;
                $display("FAIL partial_write%0d: got %h@%h/%h expected %h@%h/%h", i,
                         cap_data[res_w0+i], cap_addr[res_w0+i], cap_strb[res_w0+i],
                         exp_data[i], exp_addr[i], exp_strb[i]);
            end
        end
        checks++;
        if (res_done !== 1'b1 || res_err !== 1'b0) begin
            failures++;
            $display("FAIL partial_done: got done=%0d err=%0d expected 1/0", res_done, res_err);
        end
    endtask

    task automatic test_backpressure();
        int w0 = cap_addr.size();
        mem_ready = 1'b0;
        @(posedge sys_clk); #1;
        start     = 1'b1;
        base_addr = 14'h0203;
        @(posedge sys_clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(17 * (i + 1));
            s_last  = (i == 3);
            @(negedge sys_clk);
            checks++;
            if ({s_ready, busy} !== 2'b11) begin
                failures++;
                $display("FAIL bp_recv%0d: got ready/busy=%b expected 11", i, {s_ready, busy});
            end
            @(posedge sys_clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) mem_ready = 1'b1;
            @(negedge sys_clk);
            checks++;
            if ({mem_we, s_ready, mem_addr, mem_wdata, mem_wstrb} !==
                {1'b1, 1'b0, 14'h0200, 32'h4433_2211, 4'hF}) begin
                failures++;
                $display("FAIL bp_hold%0d: got we=%b rdy=%b %h@%h/%h expected 1 0 44332211@0200/f",
                         c, mem_we, s_ready, mem_wdata, mem_addr, mem_wstrb);
            end
            @(posedge sys_clk); #1;
        end
        mem_ready = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({mem_we, done} !== 2'b01 || cap_addr.size() - w0 != 1) begin
            failures++;
            $display("FAIL bp_complete: got we/done=%b writes=%0d expected 01/1",
                     {mem_we, done}, cap_addr.size() - w0);
        end
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    task automatic test_overflow();
        set_img(64'h8877_6655_4433_2211, 8);
        build_model(14'h3FFC);
        run_load(14'h3FFC, 80, 50, 1'b0);
        checks++;
        if (res_nw != 1) begin
            failures++;
            $display("FAIL ovf_count: got %0d expected 1", res_nw);
        end
        if (res_nw >= 1) begin
            checks++;
            if ({cap_addr[res_w0], cap_data[res_w0], cap_strb[res_w0]} !==
                {exp_addr[0], exp_data[0], exp_strb[0]}) begin
                failures++;
                $display("FAIL ovf_write: got %h@%h/%h expected %h@%h/%h",
                         cap_data[res_w0], cap_addr[res_w0], cap_strb[res_w0],
                         exp_data[0], exp_addr[0], exp_strb[0]);
            end
        end
        checks++;
        if (res_err !== 1'b1 || res_dones != 1 || res_taken != 8) begin
            failures++;
            $display("FAIL ovf_err: got err=%0d dones=%0d taken=%0d expected 1/1/8",
                     res_err, res_dones, res_taken);
        end
        checks++;
        if (res_csum !== exp_csum) begin
            failures++;
            $display("FAIL ovf_csum: got %h expected %h", res_csum, exp_csum);
        end
    endtask

    task automatic test_reset_midload();
        int taken = 0;
        int cyc   = 0;
        @(posedge sys_clk); #1;
        start     = 1'b1;
        base_addr = 14'h0040;
        @(posedge sys_clk); #1;
        start     = 1'b0;
        mem_ready = 1'b1;
        while (taken < 6 && cyc < 100) begin
            s_valid = 1'b1;
            s_data  = 8'($urandom);
            s_last  = 1'b0;
            @(negedge sys_clk);
            if (s_ready === 1'b1) taken++;
            @(posedge sys_clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || taken != 6) begin
            failures++;
            $display("FAIL midrst_busy: got busy=%0d taken=%0d expected 1/6", busy, taken);
        end
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst   = 1'b0;
        mem_ready = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({mem_we, busy, s_ready, mem_wstrb} !== 7'b0) begin
            failures++;
            $display("FAIL midrst_idle: got we/busy/rdy/strb=%b expected 0",
                     {mem_we, busy, s_ready, mem_wstrb});
        end
        rand_img(7);
        build_model(14'h0000);
        run_load(14'h0000, 100, 100, 1'b0);
        checks++;
        if (res_nw != 2) begin
            failures++;
            $display("FAIL midrst_count: got %0d expected 2", res_nw);
        end
        for (int i = 0; i < res_nw && i < exp_addr.size(); i++) begin
            checks++;
            if ({cap_addr[res_w0+i], cap_data[res_w0+i], cap_strb[res_w0+i]} !==
                {exp_addr[i], exp_data[i], exp_strb[i]}) begin
                failures++;
                $display("FAIL midrst_write%0d: got %h@%h/%h expected %h@%h/%h", i,
                         cap_data[res_w0+i], cap_addr[res_w0+i], cap_strb[res_w0+i],
                         exp_data[i], exp_addr[i], exp_strb[i]);
            end
        end
    endtask

    task automatic test_first_byte_last();
        s_valid = 1'b1;
        s_data  = 8'h5A;
        s_last  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            checks++;
            if ({s_ready, mem_we, busy} !== 3'b000) begin
                failures++;
                $display("FAIL idle_valid%0d: got rdy/we/busy=%b expected 000", c,
                         {s_ready, mem_we, busy});
            end
            @(posedge sys_clk); #1;
        end
        set_img(64'h5A, 1);
        build_model(14'h1235);
        run_load(14'h1235, 100, 100, 1'b0);
        checks++;
        if (res_nw != 1 || res_dones != 1) begin
            failures++;
            $display("FAIL single_count: got writes=%0d dones=%0d expected 1/1", res_nw, res_dones);
        end
        if (res_nw >= 1) begin
            checks++;
            if ({cap_addr[res_w0], cap_data[res_w0], cap_strb[res_w0]} !==
                {14'h1234, 32'h0000_005A, 4'b0001}) begin
                failures++;
                $display("FAIL single_write: got %h@%h/%h expected 0000005a@1234/1",
                         cap_data[res_w0], cap_addr[res_w0], cap_strb[res_w0]);
            end
        end
    endtask

    task automatic test_csum();
        logic [31:0] want;
`ifdef IMEM_LOADER_CSUM_EN
        want = 32'h0000_0201;
`else
        want = 32'h0;
`endif
        set_img(64'hFFFF_0201, 4);
        run_load(14'h0800, 100, 100, 1'b0);
        checks++;
        if (res_csum !== want || res_done !== 1'b1) begin
            failures++;
            $display("FAIL csum_fixed: got %h done=%0d expected %h done=1", res_csum, res_done, want);
        end
        @(negedge sys_clk);
        checks++;
        if (csum !== want) begin
            failures++;
            $display("FAIL csum_hold: got %h expected %h", csum, want);
        end
        @(posedge sys_clk); #1;
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] base;
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(3) == 0) base = ADDR_W'(MEM_BYTES - int'($urandom_range(1, 40)));
            else base = ADDR_W'($urandom);
            rand_img(int'($urandom_range(1, 24)));
            build_model(base);
            run_load(base, int'($urandom_range(40, 100)), int'($urandom_range(30, 100)), t[0]);
            checks++;
            if (res_nw != exp_addr.size() || res_taken != img.size() || res_dones != 1) begin
                failures++;
                $display("FAIL rand%0d_shape: got writes=%0d taken=%0d dones=%0d expected %0d/%0d/1",
                         t, res_nw, res_taken, res_dones, exp_addr.size(), img.size());
            end
            for (int i = 0; i < res_nw && i < exp_addr.size(); i++) begin
                checks++;
                if ({cap_addr[res_w0+i], cap_data[res_w0+i], cap_strb[res_w0+i]} !==
                    {exp_addr[i], exp_data[i], exp_strb[i]}) begin
                    failures++;
                    $display("FAIL rand%0d_write%0d: got %h@%h/%h expected %h@%h/%h", t, i,
                             cap_data[res_w0+i], cap_addr[res_w0+i], cap_strb[res_w0+i],
                             exp_data[i], exp_addr[i], exp_strb[i]);
                end
            end
            checks++;
            if (res_err !== exp_err || res_csum !== exp_csum) begin
                failures++;
                $display("FAIL rand%0d_status: got err=%0d csum=%h expected err=%0d csum=%h",
                         t, res_err, res_csum, exp_err, exp_csum);
            end
        end
    endtask

    initial begin
        test_reset();
        test_words();
        test_partial_word();
        test_backpressure();
        test_overflow();
        test_reset_midload();
        test_first_byte_last();
        test_csum();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
